// File: rtl/dispatch_buffer.sv
// -----------------------------------------------------------------------------
// dispatch_buffer
//
// Two-wide in-order FIFO between the renamer and the reservation-station
// dispatch logic. Each cycle it accepts up to two renamed packets (slot 0 is
// the older one) and presents the two oldest entries to dispatch. Dispatch
// pops strictly in order. The renamer is told to hold (stop) whenever fewer
// than two free entries remain. A flush empties the buffer in one cycle.
//
// Ports
//   clock      in   1         single clock, all state changes on posedge
//   reset      in   1         synchronous, active-low
//   flush      in   1         synchronous full clear (mispredict/exception)
//   in_valid   in   2         [0]=older slot, [1]=younger slot from renamer
//   in_pkt_0   in   PKT_W     older incoming packet
//   in_pkt_1   in   PKT_W     younger incoming packet
//   stop       out  1         to renamer: hold, do not present new packets
//   out_valid  out  2         [0]=head valid, [1]=head+1 valid
//   out_pkt_0  out  PKT_W     packet at head
//   out_pkt_1  out  PKT_W     packet at head+1
//   out_ready  in   2         dispatch accepts slot 0 / slot 1 this cycle
//   count      out  AW+1      current occupancy
// -----------------------------------------------------------------------------
module dispatch_buffer #(
  parameter int DEPTH = 8,
  parameter int PKT_W = 128
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [PKT_W-1:0]         in_pkt_0,
  input  logic [PKT_W-1:0]         in_pkt_1,
  output logic                     stop,
  output logic [1:0]               out_valid,
  output logic [PKT_W-1:0]         out_pkt_0,
  output logic [PKT_W-1:0]         out_pkt_1,
  input  logic [1:0]               out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  // Two free slots are needed to accept a full two-wide group.
  localparam logic [CW-1:0] STOP_LVL = CW'(DEPTH - 2);

  // Storage and pointers
  logic [PKT_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [CW-1:0]    count_r;

  // Per-cycle control
  logic             stop_s;
  logic [1:0]       out_valid_s;
  logic [AW-1:0]    head_plus1_s;
  logic [AW-1:0]    tail_plus1_s;
  logic [1:0]       n_push_s;
  logic [1:0]       n_pop_s;
  logic [PKT_W-1:0] wr_pkt_a_s;
  logic [PKT_W-1:0] wr_pkt_b_s;
  logic             update_en_s;

  // Occupancy-derived status; stop takes no credit for a same-cycle pop.
  always_comb begin
    stop_s         = (count_r > STOP_LVL);
    out_valid_s    = 2'b00;
    out_valid_s[0] = (count_r >= CNT_ONE);
    out_valid_s[1] = (count_r >= CNT_TWO);
    head_plus1_s   = head_r + PTR_ONE;
    tail_plus1_s   = tail_r + PTR_ONE;
    update_en_s    = reset && !flush;
  end

  // Push decode: oldest valid packet goes to tail, a second one to tail+1.
  always_comb begin
    n_push_s   = 2'd0;
    wr_pkt_a_s = in_pkt_0;
    wr_pkt_b_s = in_pkt_1;
    case (in_valid)
      2'b11: begin
        n_push_s   = 2'd2;
        wr_pkt_a_s = in_pkt_0;
        wr_pkt_b_s = in_pkt_1;
      end
      2'b01: begin
        n_push_s   = 2'd1;
        wr_pkt_a_s = in_pkt_0;
      end
      // Younger-only is a protocol violation upstream; keep the packet anyway.
      2'b10: begin
        n_push_s   = 2'd1;
        wr_pkt_a_s = in_pkt_1;
      end
      default: begin
        n_push_s = 2'd0;
      end
    endcase
    if (stop_s) begin
      n_push_s = 2'd0;
    end else begin
      n_push_s = n_push_s;
    end
  end

  // Pop decode: slot 1 can only leave together with slot 0.
  always_comb begin
    n_pop_s = 2'd0;
    if (out_valid_s[0] && out_ready[0]) begin
      if (out_valid_s[1] && out_ready[1]) begin
        n_pop_s = 2'd2;
      end else begin
        n_pop_s = 2'd1;
      end
    end else begin
      n_pop_s = 2'd0;
    end
  end

  // Pointer and occupancy registers; reset beats flush beats push/pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (flush) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      head_r  <= head_r + AW'(n_pop_s);
      tail_r  <= tail_r + AW'(n_push_s);
      count_r <= count_r + CW'(n_push_s) - CW'(n_pop_s);
    end
  end

  // Packet storage write port; contents are not reset, validity comes from count.
  always_ff @(posedge clock) begin
    if (update_en_s) begin
      if (n_push_s != 2'd0) begin
        mem_r[tail_r] <= wr_pkt_a_s;
      end
      if (n_push_s == 2'd2) begin
        mem_r[tail_plus1_s] <= wr_pkt_b_s;
      end
    end
  end

  // Output drive: combinational read of the two oldest entries.
  always_comb begin
    stop      = stop_s;
    out_valid = out_valid_s;
    count     = count_r;
    out_pkt_0 = mem_r[head_r];
    out_pkt_1 = mem_r[head_plus1_s];
  end

endmodule
